fetch_unit: RTL and testbench

- Instruction-fetch stage of the 8-bit CPU, sitting directly upstream of the 256x12 program ROM.
- Owns the program counter and drives the ROM address.
- Latches the 12-bit ROM word into an instruction register and splits it into a 4-bit opcode and an 8-bit operand.
- Presents the instruction to the execute/control stage over a valid/ready handshake and accepts jump redirects from it.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/program_counter.sv | 35 +++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, opcode map and fetch-stage state encoding for the 8-bit CPU.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 12;
  localparam int OPC_W   = 4;

  localparam logic [OPC_W-1:0] OP_LOAD = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OPC_W-1:0] OP_OUT  = 4'h5;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h6;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'h7;
  localparam logic [OPC_W-1:0] OP_HALT = 4'h9;
  localparam logic [OPC_W-1:0] OP_IN   = 4'hF;

  localparam logic [INSTR_W-1:0] HALT_WORD_DFLT = 12'h9FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter: load beats increment; increment past 8'hFF and loads of 0
// both land on RESET_PC so address 0 is never fetched.
module program_counter
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_inc_pc;
  logic [ADDR_W-1:0] w_load_pc;

  assign w_inc_pc  = (r_pc == {ADDR_W{1'b1}}) ? RESET_PC : r_pc + 1'b1;
  assign w_load_pc = (load_addr == '0) ? RESET_PC : load_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (load) begin
      r_pc <= w_load_pc;
    end else if (inc) begin
      r_pc <= w_inc_pc;
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, latches ROM words into the IR and
// hands them downstream over valid/ready, honouring jump redirects.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 8'd1,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DFLT,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [7:0]         operand,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic [INSTR_W-1:0] r_ir;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_instr_valid;
  logic               r_halted;
  logic [CNT_W-1:0]   r_retired;

  logic [ADDR_W-1:0]  w_pc;
  logic               w_inc;
  logic               w_load;
  logic               w_ir_load;
  logic               w_halt_set;
  logic               w_hs;

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .inc       (w_inc),
    .load      (w_load),
    .load_addr (jump_addr),
    .pc        (w_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_inc      = 1'b0;
    w_load     = 1'b0;
    w_ir_load  = 1'b0;
    w_halt_set = 1'b0;
    w_hs       = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) w_next = FETCH;
      end
      FETCH: begin
        if (en) begin
          if (rom_data == HALT_WORD) begin
            w_halt_set = 1'b1;
            w_next     = HALT;
          end else begin
            w_ir_load = 1'b1;
            w_inc     = 1'b1;
            w_next    = HOLD;
          end
        end
      end
      HOLD: begin
        // jump_en only matters on the handshake cycle
        if (r_instr_valid && instr_ready) begin
          w_hs   = 1'b1;
          w_load = jump_en;
          w_next = FETCH;
        end
      end
      HALT: begin
        w_next = HALT;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir          <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_retired     <= '0;
    end else begin
      if (w_ir_load) begin
        r_ir          <= rom_data;
        r_instr_pc    <= w_pc;
        r_instr_valid <= 1'b1;
      end else if (w_hs) begin
        r_instr_valid <= 1'b0;
      end
      if (w_halt_set) r_halted <= 1'b1;
      if (w_hs && (r_retired != {CNT_W{1'b1}})) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  assign rom_addr    = w_pc;
  assign instr_valid = r_instr_valid;
  assign opcode      = r_ir[INSTR_W-1:INSTR_W-OPC_W];
  assign operand     = r_ir[7:0];
  assign instr_pc    = r_instr_pc;
  assign halted      = r_halted;
  assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit driving a behavioural 256x12 ROM; expected
// values are hand-derived from the fetch/handshake timing.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  opcode;
  logic [7:0]  operand;
  logic [7:0]  instr_pc;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        halted;
  logic [15:0] retired;

  logic [11:0] rom [256];
  int n_checks = 0;
  int n_errors = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .operand     (operand),
    .instr_pc    (instr_pc),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halted      (halted),
    .retired     (retired)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // one HOLD snapshot: valid, instruction fields, PC and retired count
  task automatic chk_hold(input string tag, input logic [3:0] opc, input logic [7:0] opd,
                          input logic [7:0] ipc, input logic [7:0] addr, input logic [15:0] ret);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
    chk({tag, ".opcode"}, 32'(opcode), 32'(opc));
    chk({tag, ".operand"}, 32'(operand), 32'(opd));
    chk({tag, ".instr_pc"}, 32'(instr_pc), 32'(ipc));
    chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(addr));
    chk({tag, ".retired"}, 32'(retired), 32'(ret));
  endtask

  task automatic chk_fetch(input string tag, input logic [7:0] addr, input logic [15:0] ret);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(addr));
    chk({tag, ".retired"}, 32'(retired), 32'(ret));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {4'h1, 8'(i)};
    rom[0]  = 12'h9FF;
    rom[1]  = 12'hF00;
    rom[2]  = 12'h500;
    rom[14] = 12'h9FF;

    rst = 1'b1; en = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst.valid", 32'(instr_valid), 32'd0);
    chk("rst.rom_addr", 32'(rom_addr), 32'd1);
    chk("rst.instr_pc", 32'(instr_pc), 32'd0);
    chk("rst.opcode", 32'(opcode), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.retired", 32'(retired), 32'd0);

    // sequential fetch with ready held high
    rst = 1'b0; en = 1'b1; instr_ready = 1'b1;
    step(); chk_fetch("t1.fetch1", 8'd1, 16'd0);
    step(); chk_hold("t1.hold1", 4'hF, 8'h00, 8'd1, 8'd2, 16'd0);
    step(); chk_fetch("t1.fetch2", 8'd2, 16'd1);
    step(); chk_hold("t1.hold2", 4'h5, 8'h00, 8'd2, 8'd3, 16'd1);

    // stall in HOLD
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); chk_hold("t2.stall", 4'h5, 8'h00, 8'd2, 8'd3, 16'd1);
    end
    instr_ready = 1'b1;
    step(); chk_fetch("t2.release", 8'd3, 16'd2);
    step(); chk_hold("t2.hold3", 4'h1, 8'h03, 8'd3, 8'd4, 16'd2);

    // jump on handshake, ignored jump while stalled, jump to 0
    jump_en = 1'b1; jump_addr = 8'h05;
    step(); chk_fetch("t3.jfetch", 8'd5, 16'd3);
    jump_en = 1'b0;
    step(); chk_hold("t3.jhold", 4'h1, 8'h05, 8'd5, 8'd6, 16'd3);
    instr_ready = 1'b0; jump_en = 1'b1; jump_addr = 8'h20;
    repeat (2) step();
    chk_hold("t3.nojump", 4'h1, 8'h05, 8'd5, 8'd6, 16'd3);
    instr_ready = 1'b1; jump_addr = 8'h00;
    step(); chk_fetch("t3.jzero", 8'd1, 16'd4);
    jump_en = 1'b0;
    step(); chk_hold("t3.jzhold", 4'hF, 8'h00, 8'd1, 8'd2, 16'd4);

    // wrap at 8'hFF
    jump_en = 1'b1; jump_addr = 8'hFF;
    step(); chk_fetch("t5.jff", 8'hFF, 16'd5);
    jump_en = 1'b0;
    step(); chk_hold("t5.holdff", 4'h1, 8'hFF, 8'hFF, 8'd1, 16'd5);
    step(); chk_fetch("t5.wrap", 8'd1, 16'd6);
    step(); chk_hold("t5.wraphold", 4'hF, 8'h00, 8'd1, 8'd2, 16'd6);

    // en low while in FETCH
    en = 1'b0;
    step(); chk_fetch("t6.en0a", 8'd2, 16'd7);
    for (int i = 0; i < 3; i++) begin
      step(); chk_fetch("t6.en0", 8'd2, 16'd7);
    end
    en = 1'b1; instr_ready = 1'b0;
    step(); chk_hold("t6.en1", 4'h5, 8'h00, 8'd2, 8'd3, 16'd7);

    // asynchronous reset mid-HOLD, checked before the next rising edge
    #2 rst = 1'b1;
    #1;
    chk("t6.arst.valid", 32'(instr_valid), 32'd0);
    chk("t6.arst.rom_addr", 32'(rom_addr), 32'd1);
    chk("t6.arst.instr_pc", 32'(instr_pc), 32'd0);
    chk("t6.arst.opcode", 32'(opcode), 32'd0);
    chk("t6.arst.operand", 32'(operand), 32'd0);
    chk("t6.arst.retired", 32'(retired), 32'd0);
    chk("t6.arst.halted", 32'(halted), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; instr_ready = 1'b1;
    step(); chk_fetch("t6.refetch", 8'd1, 16'd0);
    step(); chk_hold("t6.rehold", 4'hF, 8'h00, 8'd1, 8'd2, 16'd0);

    // halt word at address 14
    jump_en = 1'b1; jump_addr = 8'd13;
    step(); chk_fetch("t4.j13", 8'd13, 16'd1);
    jump_en = 1'b0;
    step(); chk_hold("t4.hold13", 4'h1, 8'h0D, 8'd13, 8'd14, 16'd1);
    step(); chk_fetch("t4.fetch14", 8'd14, 16'd2);
    chk("t4.pre_halted", 32'(halted), 32'd0);
    step();
    chk("t4.halted", 32'(halted), 32'd1);
    chk_fetch("t4.halt", 8'd14, 16'd2);
    chk("t4.instr_pc", 32'(instr_pc), 32'd13);
    jump_addr = 8'h05;
    for (int i = 0; i < 4; i++) begin
      en = i[0]; instr_ready = ~i[0]; jump_en = i[1];
      step();
      chk("t4.stuck.halted", 32'(halted), 32'd1);
      chk_fetch("t4.stuck", 8'd14, 16'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
